// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types, sizes and arbitration helpers for the 4-way round-robin packet mux.
package mux4_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int STALL_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // First requester found when scanning from ptr upward, wrapping mod 4.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req_v,
                                               input logic [SEL_W-1:0]   ptr_v);
    logic [SEL_W-1:0] idx_s;
    logic             found_s;
    rr_pick = ptr_v;
    found_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_s = ptr_v + SEL_W'(i);
      if (!found_s && req_v[idx_s]) begin
        rr_pick = idx_s;
        found_s = 1'b1;
      end
    end
  endfunction

  // Index to one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [SEL_W-1:0] idx_v);
    to_onehot        = {NUM_REQ{1'b0}};
    to_onehot[idx_v] = 1'b1;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4_4bit.sv
// One 4-bit slice of the data path: a plain 4:1 multiplexer.
module mux4_4bit
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic [3:0]       c,
  input  logic [3:0]       d,
  input  logic [SEL_W-1:0] sel,
  output logic [3:0]       y
);

  // Select one nibble according to sel.
  always_comb begin
    y = 4'h0;
    case (sel)
      2'd0:    y = a;
      2'd1:    y = b;
      2'd2:    y = c;
      2'd3:    y = d;
      default: y = 4'h0;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter feeding a 4:1 packet mux. A grant is locked until the
// granted requester completes a last-beat transfer or stalls out (timeout).
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last,
  input  logic [WIDTH-1:0]   in0,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic [WIDTH-1:0]   in3,
  output logic [NUM_REQ-1:0] in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               abort
);

  localparam logic [STALL_W-1:0] TO_LIM = STALL_W'(TIMEOUT);

  state_t               state_r, state_s;
  logic [SEL_W-1:0]     ptr_r, ptr_s;
  logic [SEL_W-1:0]     sel_r, sel_s;
  logic [NUM_REQ-1:0]   gnt_r, gnt_s;
  logic [STALL_W-1:0]   stall_r, stall_s;
  logic                 abort_r, abort_s;
  logic                 sel_req_s;

  assign sel_req_s = req[sel_r];

  // Next-state, grant, pointer and stall-counter decisions.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    sel_s   = sel_r;
    gnt_s   = gnt_r;
    stall_s = stall_r;
    abort_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req != 4'b0000) begin
          sel_s   = rr_pick(req, ptr_r);
          gnt_s   = to_onehot(sel_s);
          stall_s = 8'd0;
          state_s = BUSY;
        end else begin
          gnt_s   = 4'b0000;
        end
      end
      BUSY: begin
        if (sel_req_s) begin
          // Backpressure (out_ready low) is not a stall; last only counts on a transfer.
          stall_s = 8'd0;
          if (out_ready && last[sel_r]) begin
            state_s = IDLE;
            gnt_s   = 4'b0000;
            ptr_s   = sel_r + 2'd1;
          end else begin
            state_s = BUSY;
          end
        end else begin
          if ((stall_r + 8'd1) == TO_LIM) begin
            abort_s = 1'b1;
            state_s = IDLE;
            gnt_s   = 4'b0000;
            ptr_s   = sel_r + 2'd1;
            stall_s = 8'd0;
          end else begin
            stall_s = stall_r + 8'd1;
          end
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = 4'b0000;
        stall_s = 8'd0;
      end
    endcase
  end

  // Control state registers; reset abandons any packet without an abort pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= 2'd0;
      sel_r   <= 2'd0;
      gnt_r   <= 4'b0000;
      stall_r <= 8'd0;
      abort_r <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      sel_r   <= sel_s;
      gnt_r   <= gnt_s;
      stall_r <= stall_s;
      abort_r <= abort_s;
    end
  end

  assign gnt       = gnt_r;
  assign sel       = sel_r;
  assign abort     = abort_r;
  assign busy      = (state_r == BUSY);
  assign out_valid = (state_r == BUSY) & sel_req_s;
  assign in_ready  = gnt_r & {NUM_REQ{out_ready}};

  // Data path: one nibble-wide mux per 4 bits of WIDTH.
  for (genvar g = 0; g < WIDTH / 4; g++) begin : g_slice
    mux4_4bit u_mux (
      .a   (in0[g*4 +: 4]),
      .b   (in1[g*4 +: 4]),
      .c   (in2[g*4 +: 4]),
      .d   (in3[g*4 +: 4]),
      .sel (sel_r),
      .y   (out_data[g*4 +: 4])
    );
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter (WIDTH=4, TIMEOUT=15).
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] last;
  logic [3:0] in0, in1, in2, in3;
  logic [3:0] in_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       abort;

  int total = 0;
  int bad   = 0;

  mux4_rr_arbiter #(.WIDTH(4), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gnt       (gnt),
    .sel       (sel),
    .busy      (busy),
    .abort     (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 4'b0000; last = 4'b0000; out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    total++; if (sel !== 2'd0) begin bad++; $display("FAIL reset_sel got %0d want 0", sel); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (abort !== 1'b0) begin bad++; $display("FAIL reset_abort got %b want 0", abort); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready got %b want 0000", in_ready); end
  endtask

  task automatic test_single_beat();
    do_reset();
    in0 = 4'h5; in1 = 4'h6; in2 = 4'h7; in3 = 4'h9;
    req = 4'b0001; last = 4'b0001; out_ready = 1'b1;
    #1;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL sb_latency got %b want 0000", gnt); end
    cyc();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL sb_gnt got %b want 0001", gnt); end
    total++; if (busy !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("FAIL sb_busy_valid got %b%b want 11", busy, out_valid); end
    total++; if (out_data !== 4'h5) begin bad++; $display("FAIL sb_data got %h want 5", out_data); end
    total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL sb_in_ready got %b want 0001", in_ready); end
    cyc();
    req = 4'b0000; last = 4'b0000;
    #1;
    total++; if (gnt !== 4'b0000 || busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL sb_idle got gnt=%b busy=%b valid=%b want 0000/0/0", gnt, busy, out_valid); end
    cyc();
    req = 4'b1111;
    cyc();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL sb_ptr got %b want 0010", gnt); end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g;
    logic [3:0] exp_d [4];
    do_reset();
    in0 = 4'h1; in1 = 4'h2; in2 = 4'h4; in3 = 4'h8;
    exp_d[0] = 4'h1; exp_d[1] = 4'h2; exp_d[2] = 4'h4; exp_d[3] = 4'h8;
    req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      cyc();
      total++; if (gnt !== exp_g) begin bad++; $display("FAIL rot_gnt[%0d] got %b want %b", k, gnt, exp_g); end
      total++; if (out_data !== exp_d[k % 4]) begin bad++; $display("FAIL rot_data[%0d] got %h want %h", k, out_data, exp_d[k % 4]); end
      cyc();
      total++; if (gnt !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL rot_dead[%0d] got gnt=%b busy=%b want 0000/0", k, gnt, busy); end
    end
  endtask

  task automatic test_lock();
    do_reset();
    in0 = 4'h1; in1 = 4'h2; in3 = 4'h3; in2 = 4'hA;
    req = 4'b0100; last = 4'b0000; out_ready = 1'b1;
    cyc();
    req = 4'b1111;
    #1;
    total++; if (gnt !== 4'b0100 || out_data !== 4'hA) begin bad++; $display("FAIL lock_beat0 got gnt=%b data=%h want 0100/a", gnt, out_data); end
    cyc();
    in2 = 4'hB;
    #1;
    total++; if (gnt !== 4'b0100 || out_data !== 4'hB) begin bad++; $display("FAIL lock_beat1 got gnt=%b data=%h want 0100/b", gnt, out_data); end
    cyc();
    in2 = 4'hC; last = 4'b0100;
    #1;
    total++; if (gnt !== 4'b0100 || out_data !== 4'hC || out_valid !== 1'b1) begin bad++; $display("FAIL lock_beat2 got gnt=%b data=%h valid=%b want 0100/c/1", gnt, out_data, out_valid); end
    cyc();
    last = 4'b0000;
    total++; if (gnt !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL lock_end got gnt=%b busy=%b want 0000/0", gnt, busy); end
    cyc();
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL lock_next got %b want 1000", gnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 4'b0010; last = 4'b0000; out_ready = 1'b0;
    cyc();
    for (int k = 0; k < 40; k++) begin
      cyc();
      total++; if (abort !== 1'b0 || busy !== 1'b1 || gnt !== 4'b0010) begin bad++; $display("FAIL bp_hold[%0d] got abort=%b busy=%b gnt=%b want 0/1/0010", k, abort, busy, gnt); end
    end
    out_ready = 1'b1; last = 4'b0010;
    #1;
    total++; if (in_ready !== 4'b0010 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_release got in_ready=%b valid=%b want 0010/1", in_ready, out_valid); end
    cyc();
    total++; if (busy !== 1'b0 || gnt !== 4'b0000 || abort !== 1'b0) begin bad++; $display("FAIL bp_done got busy=%b gnt=%b abort=%b want 0/0000/0", busy, gnt, abort); end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b0010; last = 4'b0000; out_ready = 1'b1;
    cyc();
    cyc();
    req = 4'b0000; last = 4'b0010;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL to_valid got %b want 0", out_valid); end
    for (int s = 1; s < 15; s++) begin
      cyc();
      total++; if (busy !== 1'b1 || abort !== 1'b0) begin bad++; $display("FAIL to_stall[%0d] got busy=%b abort=%b want 1/0", s, busy, abort); end
    end
    cyc();
    total++; if (abort !== 1'b1 || busy !== 1'b0 || gnt !== 4'b0000) begin bad++; $display("FAIL to_abort got abort=%b busy=%b gnt=%b want 1/0/0000", abort, busy, gnt); end
    req = 4'b1111; last = 4'b0000;
    cyc();
    total++; if (abort !== 1'b0) begin bad++; $display("FAIL to_pulse got %b want 0", abort); end
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL to_ptr got %b want 0100", gnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0100; last = 4'b0000; out_ready = 1'b1;
    cyc();
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (gnt !== 4'b0000 || sel !== 2'd0 || busy !== 1'b0) begin bad++; $display("FAIL rm_state got gnt=%b sel=%0d busy=%b want 0000/0/0", gnt, sel, busy); end
    total++; if (out_valid !== 1'b0 || in_ready !== 4'b0000 || abort !== 1'b0) begin bad++; $display("FAIL rm_outs got valid=%b in_ready=%b abort=%b want 0/0000/0", out_valid, in_ready, abort); end
    req = 4'b1111;
    #2;
    rst_n = 1'b1;
    cyc();
    total++; if (gnt !== 4'b0001 || abort !== 1'b0) begin bad++; $display("FAIL rm_regrant got gnt=%b abort=%b want 0001/0", gnt, abort); end
  endtask

  initial begin
    rst_n = 1'b0; req = 4'b0000; last = 4'b0000; out_ready = 1'b0;
    in0 = 4'h0; in1 = 4'h0; in2 = 4'h0; in3 = 4'h0;
    test_reset();
    test_single_beat();
    test_rotation();
    test_lock();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: data width per requester; it SHALL be a multiple of 4.
REQ-002 The block SHALL have parameter TIMEOUT, default 15: the number of consecutive stalled BUSY cycles before an abort, in the range 1..255.
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, width 1: reset, asynchronous and active-low.
REQ-005 The block SHALL have port req, input, width 4: per-requester request/valid.
REQ-006 The block SHALL have port last, input, width 4: per-requester end-of-packet flag, qualified by req.
REQ-007 The block SHALL have ports in0, in1, in2, in3, input, width WIDTH each: requester data.
REQ-008 The block SHALL have port in_ready, output, width 4: per-requester accept; in_ready = gnt AND out_ready, combinational.
REQ-009 The block SHALL have port out_data, output, width WIDTH: the selected requester's data.
REQ-010 The block SHALL have ports out_valid (output, width 1) and out_ready (input, width 1): the downstream handshake.
REQ-011 The block SHALL have port gnt, output, width 4: one-hot grant, registered.
REQ-012 The block SHALL have port sel, output, width 2: the encoded grant index that drives the mux select, registered.
REQ-013 The block SHALL have port busy, output, width 1: high while in state BUSY.
REQ-014 The block SHALL have port abort, output, width 1: a one-cycle pulse on timeout.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and BUSY.
REQ-016 The block SHALL keep a 2-bit priority pointer ptr; the requester at index ptr has highest priority, then ptr+1, ptr+2, ptr+3, all mod 4.
REQ-017 In IDLE with req != 0, the block SHALL register the winning index into sel, the one-hot value into gnt, and go to BUSY on the next edge; grant latency is 1 cycle.
REQ-018 In IDLE with req == 0, the block SHALL hold gnt = 0, keep sel unchanged, and drive out_valid = 0.
REQ-019 In BUSY, out_valid SHALL equal req[sel], and out_data SHALL equal in<sel> combinationally.
REQ-020 The block SHALL define a transfer as out_valid AND out_ready in BUSY.
REQ-021 The grant SHALL be locked in BUSY: gnt and sel SHALL NOT change regardless of other requests until the packet ends or an abort occurs.
REQ-022 On a transfer with last[sel] = 1, the next state SHALL be IDLE, gnt SHALL become 0, and ptr SHALL become sel+1 mod 4.
REQ-023 A stall SHALL be any BUSY cycle with req[sel] = 0.
REQ-024 An 8-bit stall counter SHALL count consecutive stalls and clear on any BUSY cycle with req[sel] = 1 and on entry to BUSY.
REQ-025 When the stall counter reaches TIMEOUT, the block SHALL pulse abort for 1 cycle, go to IDLE, set gnt to 0, and set ptr to sel+1 mod 4.
REQ-026 A cycle with req[sel] = 1 and out_ready = 0 SHALL be a backpressure wait, SHALL NOT count as a stall, and SHALL NOT time out.
REQ-027 In the cycle of a last-transfer, out_valid SHALL still be asserted; re-arbitration SHALL occur in the following IDLE cycle, so there is one dead cycle between packets.
REQ-028 A single-beat packet (last asserted on the first transfer) SHALL complete and return to IDLE exactly as in REQ-022.
REQ-029 If last[sel] = 1 and req[sel] = 0 in the same cycle, the block SHALL ignore last.
REQ-030 Under continuous requests from all four requesters, grant order SHALL be a strict rotation with no starvation.

Reset
REQ-031 While rst_n = 0, the block SHALL force state = IDLE, ptr = 0, sel = 0, gnt = 0, stall counter = 0, abort = 0 and busy = 0, with out_valid = 0 and in_ready = 0.
REQ-032 Assertion of rst_n mid-packet SHALL abandon the packet immediately, with no abort pulse.
REQ-033 After rst_n deasserts, the first arbitration SHALL favour requester 0.

Structure
REQ-034 A shared package SHALL hold the state enum (IDLE, BUSY), NUM_REQ = 4, SEL_W = 2 and the stall counter width of 8.
REQ-035 The data path SHALL be WIDTH/4 instances of the existing mux4_4bit sub-module, driven by sel.
REQ-036 All control logic (arbiter, FSM, counter) SHALL be in this module; no other sub-module is permitted.

Verification
REQ-037 Scenario, single beat: from reset, req = 0001, last = 0001, out_ready = 1 -> gnt = 0001 one cycle later, one transfer, back in IDLE, ptr = 1.
REQ-038 Scenario, rotation: req = 1111 held with every beat last, out_ready = 1 -> grant sequence 0,1,2,3,0, one dead cycle between grants.
REQ-039 Scenario, lock: requester 2 sends a 3-beat packet (in2 = 4'hA, 4'hB, 4'hC) while req = 1111 -> out_data = A, B, C, with gnt held at 0100 throughout.
REQ-040 Scenario, backpressure: granted requester holds req with out_ready = 0 for 40 cycles -> no abort; the transfer completes when out_ready rises.
REQ-041 Scenario, timeout: TIMEOUT = 15; the granted requester drops req mid-packet -> abort pulses on the 15th stall cycle, then IDLE, and ptr advances.
REQ-042 Scenario, reset mid-packet: rst_n asserted in BUSY -> all outputs go to reset values immediately, and the next grant goes to requester 0.
